sync_arith_unit: RTL and testbench

- Registered, single-cycle arithmetic unit for BITS-wide two's-complement operands.
- Four operations (add, subtract, signed less-than compare, negate), selected by a 2-bit opcode.
- Produces a BITS-wide result plus a 4-bit status vector; both are registered.
- Used as a datapath leaf block. The flow-through model and the gate-level form share this exact interface and behaviour.

---
 rtl/sync_arith_unit.sv | 100 ++++++++++
 tb/tb_sync_arith_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sync_arith_unit.sv
// -----------------------------------------------------------------------------
// sync_arith_unit
//   Registered single-cycle arithmetic leaf for BITS-wide two's-complement
//   operands. One-cycle latency, no handshake, a new op may issue every cycle.
//
//   Ports:
//     i_clk     in   1     clock, rising edge
//     i_reset   in   1     synchronous active-high reset (clears outputs)
//     i_arg_A   in   BITS  operand A
//     i_arg_B   in   BITS  operand B (ignored by NEG)
//     i_op      in   2     00 ADD, 01 SUB, 10 SLT (signed), 11 NEG
//     o_result  out  BITS  registered result
//     o_status  out  4     registered flags {PAR, NEG, ZERO, OVF}
//
//   Build option:
//     ARITH_SATURATE_EN  when defined, overflowing ADD/SUB/NEG clamp to the
//                        most-positive / most-negative value instead of
//                        wrapping. OVF stays set; the other flags follow the
//                        clamped value.
// -----------------------------------------------------------------------------
module sync_arith_unit #(
    parameter int BITS = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [BITS-1:0] i_arg_A,
    input  logic [BITS-1:0] i_arg_B,
    input  logic [1:0]      i_op,
    output logic [BITS-1:0] o_result,
    output logic [3:0]      o_status
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_SLT = 2'b10,
        OP_NEG = 2'b11
    } op_e;

    localparam logic [BITS-1:0] MAX_POS = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0] MAX_NEG = {1'b1, {(BITS-1){1'b0}}};

    logic [BITS-1:0] sum, diff, negv, raw, fin;
    logic            a_s, b_s, slt, ovf;

    assign a_s  = i_arg_A[BITS-1];
    assign b_s  = i_arg_B[BITS-1];
    assign sum  = i_arg_A + i_arg_B;
    assign diff = i_arg_A - i_arg_B;
    assign negv = '0 - i_arg_A;
    assign slt  = $signed(i_arg_A) < $signed(i_arg_B);

    always_comb begin
        raw = sum;
        ovf = 1'b0;
        case (op_e'(i_op))
            OP_ADD: begin
                raw = sum;
                ovf = (a_s == b_s) && (sum[BITS-1] != a_s);
            end
            OP_SUB: begin
                raw = diff;
                ovf = (a_s != b_s) && (diff[BITS-1] != a_s);
            end
            OP_SLT: begin
                raw = {{(BITS-1){1'b0}}, slt};
                ovf = 1'b0;
            end
            OP_NEG: begin
                raw = negv;
                ovf = (i_arg_A == MAX_NEG);
            end
            default: begin
                raw = sum;
                ovf = 1'b0;
            end
        endcase
    end

`ifdef ARITH_SATURATE_EN
    // On ADD/SUB overflow the true result carries A's sign; NEG can only
    // overflow on the most-negative input, whose true negation is positive.
    logic sat_to_neg;
    assign sat_to_neg = a_s && (op_e'(i_op) != OP_NEG);
    assign fin = !ovf ? raw : (sat_to_neg ? MAX_NEG : MAX_POS);
`else
    assign fin = raw;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_result <= '0;
            o_status <= '0;
        end else begin
            o_result <= fin;
            o_status <= {^fin, fin[BITS-1], (fin == '0), ovf};
        end
    end

endmodule

// File: tb/tb_sync_arith_unit.sv
// -----------------------------------------------------------------------------
// tb_sync_arith_unit
//   Directed vector table (applied on consecutive cycles) followed by random
//   traffic checked against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_sync_arith_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [1:0]  op = '0;
    logic [31:0] res;
    logic [3:0]  st;

    int n_chk  = 0;
    int n_pass = 0;

    sync_arith_unit #(.BITS(32)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_arg_A  (a),
        .i_arg_B  (b),
        .i_op     (op),
        .o_result (res),
        .o_status (st)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp_r;
        logic [3:0]  exp_s;
    } vec_t;

    vec_t vecs[$];

    // Reference: evaluate on wide signed integers, detect overflow as the
    // true value leaving the 32-bit signed range.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic [1:0] mop,
                                  output logic [31:0] r, output logic [3:0] s);
        longint sa, sb, t;
        logic   v;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        case (mop)
            2'd0:    t = sa + sb;
            2'd1:    t = sa - sb;
            2'd2:    t = (sa < sb) ? 64'sd1 : 64'sd0;
            default: t = -sa;
        endcase
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        r = t[31:0];
`ifdef ARITH_SATURATE_EN
        if (v) r = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        s = {^r, r[31], (r == 32'd0), v};
    endfunction

    task automatic check(input string name, input logic [31:0] er, input logic [3:0] es);
        n_chk++;
        if (res === er) n_pass++;
        else $display("FAIL %s result: got %h want %h", name, res, er);
        n_chk++;
        if (st === es) n_pass++;
        else $display("FAIL %s status: got %h want %h", name, st, es);
    endtask

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    task automatic step(input logic r, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [1:0] iop);
        @(negedge clk);
        rst = r; a = ia; b = ib; op = iop;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] er;
        logic [3:0]  es;
        string       nm;

        // 0x12345679 has an even number of set bits, so PAR is 0 there.
        vecs.push_back('{1'b1, 32'h1234_5678, 32'h1, 2'd0, 32'h0, 4'h0});
        vecs.push_back('{1'b0, 32'h1234_5678, 32'h1, 2'd0, 32'h1234_5679, 4'h0});
`ifdef ARITH_SATURATE_EN
        vecs.push_back('{1'b0, 32'h7FFF_FFFF, 32'h1, 2'd0, 32'h7FFF_FFFF, 4'h9});
`else
        vecs.push_back('{1'b0, 32'h7FFF_FFFF, 32'h1, 2'd0, 32'h8000_0000, 4'hD});
`endif
        // SUB/SUB/SLT/SLT/NEG/NEG issued back to back
        vecs.push_back('{1'b0, 32'h5, 32'h5, 2'd1, 32'h0, 4'h2});
        vecs.push_back('{1'b0, 32'h0, 32'h1, 2'd1, 32'hFFFF_FFFF, 4'h4});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h1, 4'h8});
        vecs.push_back('{1'b0, 32'h1, 32'hFFFF_FFFF, 2'd2, 32'h0, 4'h2});
`ifdef ARITH_SATURATE_EN
        vecs.push_back('{1'b0, 32'h8000_0000, 32'h0, 2'd3, 32'h7FFF_FFFF, 4'h9});
`else
        vecs.push_back('{1'b0, 32'h8000_0000, 32'h0, 2'd3, 32'h8000_0000, 4'hD});
`endif
        vecs.push_back('{1'b0, 32'h1, 32'h0, 2'd3, 32'hFFFF_FFFF, 4'h4});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 2'd2, 32'h1, 4'h8});
`ifdef ARITH_SATURATE_EN
        vecs.push_back('{1'b0, 32'h8000_0000, 32'h1, 2'd1, 32'h8000_0000, 4'hD});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 2'd0, 32'h8000_0000, 4'hD});
`else
        vecs.push_back('{1'b0, 32'h8000_0000, 32'h1, 2'd1, 32'h7FFF_FFFF, 4'h9});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 2'd0, 32'h7FFF_FFFF, 4'h9});
`endif
        // reset mid-stream discards the op; next op lands one edge later
        vecs.push_back('{1'b1, 32'h3, 32'h4, 2'd0, 32'h0, 4'h0});
        vecs.push_back('{1'b0, 32'h3, 32'h4, 2'd0, 32'h7, 4'h8});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].op);
            nm = $sformatf("vec%0d", i);
            check(nm, vecs[i].exp_r, vecs[i].exp_s);
        end

        // Hold between edges: wait to the falling edge, outputs must not move.
        @(negedge clk);
        check("hold", 32'h7, 4'h8);

        // Random traffic, occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic        rr;
            logic [31:0] ra, rb;
            logic [1:0]  ro;
            rr = ($urandom_range(0, 15) == 0);
            ra = pick();
            rb = pick();
            ro = 2'($urandom_range(0, 3));
            step(rr, ra, rb, ro);
            if (rr) begin
                er = '0;
                es = '0;
            end else begin
                model(ra, rb, ro, er, es);
            end
            nm = $sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb);
            check(nm, er, es);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
